// File: rtl/hough_uart_pkg.sv
// Shared definitions for the Hough result record carried over UART.
// The byte order here must match the transmit-side result serializer.
package hough_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHECK   = 2'd2
    } rx_state_e;

    localparam int RESULT_BYTES = 8;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_THETA   = 2'b10;

    // Record layout: rho in bytes 0..3, theta in bytes 4..7, each LSB first.
    localparam int RHO_LSB_BYTE   = 0;
    localparam int THETA_LSB_BYTE = 4;

    function automatic logic [31:0] get_rho(input logic [63:0] rec);
        return rec[RHO_LSB_BYTE*8 +: 32];
    endfunction

    function automatic logic [31:0] get_theta(input logic [63:0] rec);
        return rec[THETA_LSB_BYTE*8 +: 32];
    endfunction

endpackage

// File: rtl/rx_gap_timer.sv
// Inter-byte gap timer: counts enabled cycles without a byte and flags expiry
// on the last cycle of the allowed gap.
module rx_gap_timer #(
    parameter int TIMEOUT_CYCLES = 8680
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    // A byte in the expiry cycle wins, so clear masks the expiry.
    assign expired = enable && !clear && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear || !enable) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/hough_result_rx.sv
// Reassembles the 8-byte (rho, theta) Hough result record from a UART byte
// stream, validates theta, and keeps good/discarded packet statistics.
module hough_result_rx
    import hough_uart_pkg::*;
#(
    parameter int CLK_FREQ      = 25000000,
    parameter int BAUD_RATE     = 115200,
    parameter int TIMEOUT_BYTES = 4,
    parameter int THETA_MAX     = 180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        res_valid,
    output logic [31:0] res_rho,
    output logic [31:0] res_theta,
    output logic        res_error,
    output logic [1:0]  err_code,
    output logic [15:0] pkt_count,
    output logic [15:0] err_count,
    output logic        busy
);
    localparam int TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * (CLK_FREQ / BAUD_RATE);
    localparam logic [2:0] LAST_IDX = 3'(RESULT_BYTES - 1);

    rx_state_e   state_q, state_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic [63:0] asm_q, asm_d;
    logic        res_valid_q, res_valid_d;
    logic        res_error_q, res_error_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [31:0] rho_q, rho_d;
    logic [31:0] theta_q, theta_d;
    logic [15:0] pkt_count_q, pkt_count_d;
    logic [15:0] err_count_q, err_count_d;

    logic        gap_expired;
    logic [31:0] theta_rx;
    logic        theta_ok;

    rx_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (rx_valid),
        .enable (state_q == ST_COLLECT),
        .expired(gap_expired)
    );

    // Theta is signed: any negative value is out of range.
    assign theta_rx = get_theta(asm_q);
    assign theta_ok = !theta_rx[31] && (theta_rx < 32'(THETA_MAX));

    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        asm_d       = asm_q;
        res_valid_d = 1'b0;
        res_error_d = 1'b0;
        err_code_d  = err_code_q;
        rho_d       = rho_q;
        theta_d     = theta_q;
        pkt_count_d = pkt_count_q;
        err_count_d = err_count_q;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    asm_d[7:0] = rx_byte;
                    byte_idx_d = 3'd1;
                    state_d    = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (rx_valid) begin
                    asm_d[{byte_idx_q, 3'b000} +: 8] = rx_byte;
                    byte_idx_d = byte_idx_q + 3'd1;
                    if (byte_idx_q == LAST_IDX) begin
                        byte_idx_d = 3'd0;
                        state_d    = ST_CHECK;
                    end
                end else if (gap_expired) begin
                    res_error_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
                    byte_idx_d  = 3'd0;
                    state_d     = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (theta_ok) begin
                    rho_d       = get_rho(asm_q);
                    theta_d     = theta_rx;
                    res_valid_d = 1'b1;
                    if (pkt_count_q != 16'hFFFF) pkt_count_d = pkt_count_q + 16'd1;
                end else begin
                    res_error_d = 1'b1;
                    err_code_d  = ERR_THETA;
                    if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
                end
                // A byte landing during the check starts the next record.
                if (rx_valid) begin
                    asm_d[7:0] = rx_byte;
                    byte_idx_d = 3'd1;
                    state_d    = ST_COLLECT;
                end else begin
                    byte_idx_d = 3'd0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                byte_idx_d = 3'd0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            byte_idx_q  <= 3'd0;
            asm_q       <= '0;
            res_valid_q <= 1'b0;
            res_error_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            rho_q       <= '0;
            theta_q     <= '0;
            pkt_count_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            asm_q       <= asm_d;
            res_valid_q <= res_valid_d;
            res_error_q <= res_error_d;
            err_code_q  <= err_code_d;
            rho_q       <= rho_d;
            theta_q     <= theta_d;
            pkt_count_q <= pkt_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_error = res_error_q;
    assign err_code  = err_code_q;
    assign res_rho   = rho_q;
    assign res_theta = theta_q;
    assign pkt_count = pkt_count_q;
    assign err_count = err_count_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hough_result_rx.sv
// Directed bench for hough_result_rx: decode, timeout, theta range,
// back-to-back packets and mid-packet reset.
module tb_hough_result_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        res_valid;
    logic [31:0] res_rho;
    logic [31:0] res_theta;
    logic        res_error;
    logic [1:0]  err_code;
    logic [15:0] pkt_count;
    logic [15:0] err_count;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    int          valid_pulses = 0;
    int          error_pulses = 0;
    int          both_high    = 0;
    logic [31:0] cap_rho[$];
    logic [31:0] cap_theta[$];

    hough_result_rx dut (
        .clk      (clk),
        .reset    (reset),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .res_valid(res_valid),
        .res_rho  (res_rho),
        .res_theta(res_theta),
        .res_error(res_error),
        .err_code (err_code),
        .pkt_count(pkt_count),
        .err_count(err_count),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (res_valid) begin
            valid_pulses++;
            cap_rho.push_back(res_rho);
            cap_theta.push_back(res_theta);
        end
        if (res_error) error_pulses++;
        if (res_valid && res_error) both_high++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered and left 1 ns after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_packet(input logic [31:0] rho, input logic [31:0] theta, input int gap);
        logic [63:0] rec;
        rec = {theta, rho};
        for (int i = 0; i < 8; i++) begin
            send_byte(rec[i*8 +: 8], (i == 7) ? 0 : gap);
        end
    endtask

    initial begin
        int cyc;
        int err_before;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        chk("rst_valid",  {31'd0, res_valid}, 32'd0);
        chk("rst_error",  {31'd0, res_error}, 32'd0);
        chk("rst_code",   {30'd0, err_code},  32'd0);
        chk("rst_rho",    res_rho,            32'd0);
        chk("rst_theta",  res_theta,          32'd0);
        chk("rst_pkt",    {16'd0, pkt_count}, 32'd0);
        chk("rst_err",    {16'd0, err_count}, 32'd0);
        chk("rst_busy",   {31'd0, busy},      32'd0);

        // Packet 1: 78 56 34 12 2D 00 00 00 at one byte per 217 cycles
        send_packet(32'h12345678, 32'd45, 216);
        chk("p1_busy_check", {31'd0, busy}, 32'd1);
        chk("p1_valid_early", {31'd0, res_valid}, 32'd0);
        tick();
        chk("p1_valid", {31'd0, res_valid}, 32'd1);
        chk("p1_rho",   res_rho,   32'h12345678);
        chk("p1_theta", res_theta, 32'd45);
        chk("p1_pkt",   {16'd0, pkt_count}, 32'd1);
        chk("p1_busy",  {31'd0, busy}, 32'd0);
        tick();
        chk("p1_valid_off", {31'd0, res_valid}, 32'd0);

        // Packet 2: rho = -1, theta = 90
        send_packet(32'hFFFFFFFF, 32'd90, 216);
        tick();
        chk("p2_valid", {31'd0, res_valid}, 32'd1);
        chk("p2_rho",   res_rho,   32'hFFFFFFFF);
        chk("p2_theta", res_theta, 32'd90);
        chk("p2_pkt",   {16'd0, pkt_count}, 32'd2);

        // Three bytes then silence: timeout 8680 cycles after the third byte
        send_byte(8'h11, 216);
        send_byte(8'h22, 216);
        send_byte(8'h33, 0);
        cyc = 0;
        for (int k = 1; k <= 10000; k++) begin
            tick();
            if (res_error) begin
                cyc = k;
                break;
            end
        end
        chk("to_cycles", cyc, 32'd8680);
        chk("to_code",  {30'd0, err_code},  32'd1);
        chk("to_errcnt", {16'd0, err_count}, 32'd1);
        chk("to_busy",  {31'd0, busy},      32'd0);
        chk("to_rho_kept", res_rho, 32'hFFFFFFFF);
        chk("to_pkt",   {16'd0, pkt_count}, 32'd2);

        // Full packet after the timeout; theta 179 is the top of the range
        send_packet(32'hCAFEBABE, 32'd179, 216);
        tick();
        chk("p3_valid", {31'd0, res_valid}, 32'd1);
        chk("p3_rho",   res_rho,   32'hCAFEBABE);
        chk("p3_theta", res_theta, 32'd179);
        chk("p3_pkt",   {16'd0, pkt_count}, 32'd3);
        chk("p3_code_holds", {30'd0, err_code}, 32'd1);

        // Theta 180: out of range, outputs keep previous values
        send_packet(32'h00000055, 32'd180, 216);
        tick();
        chk("t180_error", {31'd0, res_error}, 32'd1);
        chk("t180_valid", {31'd0, res_valid}, 32'd0);
        chk("t180_code",  {30'd0, err_code},  32'd2);
        chk("t180_rho",   res_rho,   32'hCAFEBABE);
        chk("t180_theta", res_theta, 32'd179);
        chk("t180_pkt",   {16'd0, pkt_count}, 32'd3);
        chk("t180_err",   {16'd0, err_count}, 32'd2);
        tick();
        chk("t180_error_off", {31'd0, res_error}, 32'd0);

        // Negative theta is also out of range
        send_packet(32'h00000066, 32'hFFFFFFFF, 3);
        tick();
        chk("tneg_error", {31'd0, res_error}, 32'd1);
        chk("tneg_err",   {16'd0, err_count}, 32'd3);
        chk("tneg_theta", res_theta, 32'd179);

        // Two packets on 16 consecutive strobes; theta 0 is the bottom of the range
        repeat (2) tick();
        cap_rho.delete();
        cap_theta.delete();
        cyc = valid_pulses;
        send_packet(32'h80000001, 32'd0, 0);
        send_packet(32'h7FFFFFFE, 32'd1, 0);
        repeat (3) tick();
        chk("b2b_pulses", valid_pulses - cyc, 32'd2);
        chk("b2b_pkt",    {16'd0, pkt_count}, 32'd5);
        if (cap_rho.size() == 2) begin
            chk("b2b_rho0",   cap_rho[0],   32'h80000001);
            chk("b2b_theta0", cap_theta[0], 32'd0);
            chk("b2b_rho1",   cap_rho[1],   32'h7FFFFFFE);
            chk("b2b_theta1", cap_theta[1], 32'd1);
        end else begin
            chk("b2b_capture_count", cap_rho.size(), 32'd2);
        end

        // Reset after 5 bytes, then a full packet
        err_before = error_pulses;
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 5);
        chk("mr_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_busy", {31'd0, busy},      32'd0);
        chk("mr_pkt",  {16'd0, pkt_count}, 32'd0);
        chk("mr_err",  {16'd0, err_count}, 32'd0);
        chk("mr_code", {30'd0, err_code},  32'd0);
        chk("mr_rho",  res_rho,            32'd0);
        send_packet(32'h0BADF00D, 32'd12, 7);
        tick();
        chk("mr_valid", {31'd0, res_valid}, 32'd1);
        chk("mr_rho2",  res_rho,   32'h0BADF00D);
        chk("mr_theta", res_theta, 32'd12);
        chk("mr_pkt1",  {16'd0, pkt_count}, 32'd1);
        chk("mr_err0",  {16'd0, err_count}, 32'd0);
        repeat (2) tick();
        chk("mr_no_error_pulse", error_pulses - err_before, 32'd0);
        chk("excl_valid_error", both_high, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/hough_result_rx.md
# hough_result_rx

- Receives the 8-byte Hough result record (rho, theta) from a UART byte stream and reassembles it into signed 32-bit values.
- Sits behind a `uart_top` RX port on the consuming side: a host-side FPGA, or the loopback/verification harness that checks the Sobel/Hough pipeline's result serializer.
- Detects inter-byte gaps and out-of-range theta, resynchronises on errors, and keeps packet and error statistics.

## Interface

Parameters:
- `CLK_FREQ`, 25000000: clock frequency in Hz.
- `BAUD_RATE`, 115200: UART baud rate.
- `TIMEOUT_BYTES`, 4: gap, in byte times, that aborts a partial packet.
- `THETA_MAX`, 180: valid theta range is 0..`THETA_MAX`-1.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `rx_valid` in 1: one-cycle strobe, `rx_byte` is valid.
- `rx_byte` in 8: received byte.
- `res_valid` out 1: one-cycle pulse, new result on `res_rho` / `res_theta`.
- `res_rho` out 32: signed rho; holds the last good value.
- `res_theta` out 32: signed theta; holds the last good value.
- `res_error` out 1: one-cycle pulse, packet discarded.
- `err_code` out 2: reason for `res_error`: 01 = timeout, 10 = theta range. Holds until the next error.
- `pkt_count` out 16: good packets, saturating.
- `err_count` out 16: discarded packets, saturating.
- `busy` out 1: high while a packet is partially received.

## Operation

- Packet format: 8 bytes, rho then theta, each little-endian (LSB first). No header.
- States:
  - IDLE: waits for a byte. No timeout runs here.
  - COLLECT: bytes 1..7 are stored by index `byte_idx` (0..7) into a 64-bit shift/assembly register.
  - CHECK: one cycle; validates theta and drives the outputs.
- Transitions:
  - IDLE with `rx_valid`: store byte 0, `byte_idx`=1, go to COLLECT.
  - COLLECT with `rx_valid` and `byte_idx`==7: store byte, go to CHECK.
  - COLLECT timer expiry: `res_error`=1, `err_code`=01, `err_count`+1, go to IDLE. The partial packet is dropped.
  - CHECK, theta in 0..`THETA_MAX`-1: update `res_rho`/`res_theta`, `res_valid`=1, `pkt_count`+1.
  - CHECK, theta out of range (negative or >= `THETA_MAX`): `res_error`=1, `err_code`=10, `err_count`+1. `res_rho`/`res_theta` are unchanged.
  - CHECK with `rx_valid` in the same cycle: that byte is byte 0 of the next packet; go to COLLECT with `byte_idx`=1. Otherwise go to IDLE.
- Timeout:
  - `TIMEOUT_CYCLES` = `TIMEOUT_BYTES` × 10 × (`CLK_FREQ`/`BAUD_RATE`), integer division. Default 4×10×217 = 8680.
  - The gap counter clears on every accepted byte and increments each COLLECT cycle without one.
  - Expiry occurs when the counter equals `TIMEOUT_CYCLES`-1 with no byte that cycle.
  - A byte arriving in the expiry cycle wins: it is accepted and the counter clears.
- Counters saturate at 16'hFFFF; they do not wrap.
- `busy` = (state != IDLE).

## Timing

- Reset values:
  - state IDLE, `byte_idx` 0, gap counter 0.
  - `res_valid` 0, `res_error` 0, `err_code` 00.
  - `res_rho` 0, `res_theta` 0.
  - `pkt_count` 0, `err_count` 0, `busy` 0.
- Latency: the 8th byte is sampled at edge E. State is CHECK after E. `res_valid` or `res_error` is high during the cycle after edge E+1. Result outputs change at edge E+1.
- `res_valid` and `res_error` are mutually exclusive and never high for two consecutive cycles from the same packet.
- Back-to-back packets are accepted at any byte rate, including `rx_valid` on consecutive cycles.
- Reset mid-packet discards all state. No error is flagged and counters clear.

## Structure

- Package `hough_uart_pkg` holds:
  - the state enum;
  - `RESULT_BYTES`=8;
  - error code constants `ERR_NONE`, `ERR_TIMEOUT`, `ERR_THETA`;
  - the byte-order convention, shared with the result serializer.
- One sub-module, `rx_gap_timer`:
  - parameter `TIMEOUT_CYCLES`;
  - inputs `clear`, `enable`;
  - output `expired`.
- The FSM, assembly register and counters stay in `hough_result_rx`.

## Test plan

- Bytes 78 56 34 12 2D 00 00 00, one per 217 cycles -> `res_valid` pulse, `res_rho`=0x12345678, `res_theta`=45, `pkt_count`=1.
- Bytes FF FF FF FF 5A 00 00 00 -> `res_rho`=-1, `res_theta`=90.
- 3 bytes, then silence -> `res_error` 8680 cycles after the 3rd byte, `err_code`=01, `err_count`=1. A following full packet decodes correctly.
- Theta bytes B4 00 00 00 (180) -> `res_error`, `err_code`=10, `res_rho`/`res_theta` keep the previous values, `pkt_count` unchanged.
- Two packets with `rx_valid` every cycle (16 consecutive strobes) -> two `res_valid` pulses, both values correct.
- `reset` after 5 bytes, then a full packet -> no error, correct decode, `pkt_count`=1.
